// File: rtl/calculator_pkg.sv
// Shared calculator types: scheduler state, job status and the queued job record.
package calculator_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned ID_W   = 4;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_REPORT} sched_state_t;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_TIMEOUT   = 2'd1,
      ST_BAD_RANGE = 2'd2
   } job_status_t;

   typedef struct packed {
      logic [ADDR_W-1:0] rd_start;
      logic [ADDR_W-1:0] rd_end;
      logic [ADDR_W-1:0] wr_start;
      logic [ADDR_W-1:0] wr_end;
      logic [ID_W-1:0]   id;
   } calc_job_t;

   // Two read words (lower/upper SRAM) produce one 64-bit sum, so the read span must be twice the write span.
   function automatic logic range_ok(calc_job_t j);
      logic [ADDR_W:0] rd_len;
      logic [ADDR_W:0] wr_len;
      rd_len = {1'b0, j.rd_end} - {1'b0, j.rd_start} + (ADDR_W+1)'(1);
      wr_len = {1'b0, j.wr_end} - {1'b0, j.wr_start} + (ADDR_W+1)'(1);
      return (j.rd_end >= j.rd_start) && (j.wr_end >= j.wr_start) &&
             (rd_len == {wr_len[ADDR_W-1:0], 1'b0});
   endfunction

endpackage

// File: rtl/calc_job_fifo.sv
// Synchronous job FIFO; full/empty come from pointers carrying an extra wrap bit.
module calc_job_fifo
   import calculator_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  calc_job_t din,
   output calc_job_t dout,
   output logic      full,
   output logic      empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   calc_job_t      mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/calc_job_scheduler.sv
// Queues calculator jobs and runs them one at a time on the controller, with timeout and status report.
module calc_job_scheduler
   import calculator_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [ADDR_W-1:0] job_rd_start,
   input  logic [ADDR_W-1:0] job_rd_end,
   input  logic [ADDR_W-1:0] job_wr_start,
   input  logic [ADDR_W-1:0] job_wr_end,
   output logic [ID_W-1:0]   job_id,
   output logic              ctrl_start,
   output logic              ctrl_abort,
   output logic [ADDR_W-1:0] ctrl_rd_start,
   output logic [ADDR_W-1:0] ctrl_rd_end,
   output logic [ADDR_W-1:0] ctrl_wr_start,
   output logic [ADDR_W-1:0] ctrl_wr_end,
   input  logic              ctrl_done,
   output logic              sched_busy,
   output logic              done_valid,
   output logic [ID_W-1:0]   done_id,
   output logic [1:0]        done_status,
   output logic [CNT_W-1:0]  done_cycles
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   sched_state_t     state_q, state_d;
   calc_job_t        act_q, act_d;
   calc_job_t        fifo_din, fifo_dout;
   logic [ID_W-1:0]  tag_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_q, start_d, abort_q, abort_d, dv_q, dv_d;
   logic [ID_W-1:0]  did_q, did_d;
   job_status_t      dstat_q, dstat_d;
   logic [CNT_W-1:0] dcyc_q, dcyc_d;
   logic             push, pop, full, empty;

   assign job_ready = !full;
   assign push      = job_valid && !full;
   assign job_id    = tag_q;
   assign fifo_din  = '{rd_start: job_rd_start, rd_end: job_rd_end,
                        wr_start: job_wr_start, wr_end: job_wr_end, id: tag_q};

   calc_job_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      abort_d = 1'b0;
      dv_d    = 1'b0;
      did_d   = did_q;
      dstat_d = dstat_q;
      dcyc_d  = dcyc_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               act_d   = fifo_dout;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (range_ok(act_q)) begin
               start_d = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = S_RUN;
            end else begin
               dv_d    = 1'b1;
               did_d   = act_q.id;
               dstat_d = ST_BAD_RANGE;
               dcyc_d  = '0;
               state_d = S_REPORT;
            end
         end
         S_RUN: begin
            // Completion is checked before the timeout so a coincident done is reported OK.
            if (ctrl_done) begin
               dv_d    = 1'b1;
               did_d   = act_q.id;
               dstat_d = ST_OK;
               dcyc_d  = cnt_q;
               state_d = S_REPORT;
            end else if (cnt_q == TMO) begin
               abort_d = 1'b1;
               dv_d    = 1'b1;
               did_d   = act_q.id;
               dstat_d = ST_TIMEOUT;
               dcyc_d  = TMO;
               state_d = S_REPORT;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         act_q   <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
         dv_q    <= 1'b0;
         did_q   <= '0;
         dstat_q <= ST_OK;
         dcyc_q  <= '0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         abort_q <= abort_d;
         dv_q    <= dv_d;
         did_q   <= did_d;
         dstat_q <= dstat_d;
         dcyc_q  <= dcyc_d;
         if (push) tag_q <= tag_q + ID_W'(1);
      end
   end

   assign ctrl_start    = start_q;
   assign ctrl_abort    = abort_q;
   assign ctrl_rd_start = act_q.rd_start;
   assign ctrl_rd_end   = act_q.rd_end;
   assign ctrl_wr_start = act_q.wr_start;
   assign ctrl_wr_end   = act_q.wr_end;
   assign sched_busy    = (state_q != S_IDLE) || !empty;
   assign done_valid    = dv_q;
   assign done_id       = did_q;
   assign done_status   = dstat_q;
   assign done_cycles   = dcyc_q;

endmodule

// File: doc/calc_job_scheduler.md
Name: calc_job_scheduler

Overview:
- Queues calculator jobs and sequences the calculator controller one job at a time.
- A job is a read range over the lower/upper SRAM pair plus a write range for the 64-bit sums.
- Sits between a host/bench job source and the controller: drives its range inputs and start pulse, watches its end-of-run pulse, enforces a timeout and reports per-job status and cycle count.

Parameters:
ADDR_W, 10, SRAM address width (1024 words)
DEPTH, 4, job FIFO entries (power of 2)
ID_W, 4, job tag width
CNT_W, 16, cycle-counter width
TIMEOUT, 5000, max S_RUN cycles before abort (< 2^CNT_W)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
job_valid  in  1  job offered
job_ready  out  1  FIFO can accept
job_rd_start, job_rd_end  in  ADDR_W  read range, inclusive
job_wr_start, job_wr_end  in  ADDR_W  write range, inclusive
job_id  out  ID_W  tag given to the job accepted this cycle
ctrl_start  out  1  one-cycle launch pulse to controller
ctrl_abort  out  1  one-cycle abort pulse to controller
ctrl_rd_start, ctrl_rd_end, ctrl_wr_start, ctrl_wr_end  out  ADDR_W  ranges for the active job
ctrl_done  in  1  controller reached S_END (one-cycle pulse)
sched_busy  out  1  job in flight or FIFO non-empty
done_valid  out  1  one-cycle completion report
done_id  out  ID_W  tag of the reported job
done_status  out  2  0 OK, 1 TIMEOUT, 2 BAD_RANGE
done_cycles  out  CNT_W  S_RUN cycles consumed

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs go to 0 and the FIFO empties.
  - The tag counter goes to 0 and the state to S_IDLE.
  - job_ready = !full (combinational), so it reads 1 after reset.
  - Reset mid-job drops the job silently: no ctrl_abort, no report.
- Accept: on an edge with job_valid & job_ready, push {ranges, tag}.
  - job_id = current tag; the tag increments mod 2^ID_W.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- S_IDLE: if the FIFO is non-empty, pop into the active registers (ctrl_* ranges) and go to S_LAUNCH.
  - A job accepted into an empty FIFO in S_IDLE at edge k is popped at edge k+1.
  - ctrl_start is high during the cycle after edge k+2 (launch asserts two cycles after acceptance).
- S_LAUNCH: validate the range. Valid requires all of:
  - rd_end >= rd_start
  - wr_end >= wr_start
  - (rd_end - rd_start + 1) == 2 x (wr_end - wr_start + 1), computed at ADDR_W+1 bits
  - Invalid: status=BAD_RANGE, done_cycles=0, no ctrl_start, go to S_REPORT.
  - Valid: ctrl_start=1 for this cycle only, go to S_RUN, counter set to 1.
- S_RUN: the counter increments each cycle (saturates at all-ones).
  - ctrl_done sampled high: status=OK, done_cycles=counter, go to S_REPORT.
  - Else if counter == TIMEOUT: ctrl_abort=1 for one cycle, status=TIMEOUT, done_cycles=TIMEOUT, go to S_REPORT.
  - ctrl_done and timeout in the same cycle: OK wins, no abort.
- S_REPORT: done_valid=1 for one cycle with done_id, done_status, done_cycles; go to S_IDLE.
  - done_* hold their values until the next report.
- ctrl_done outside S_RUN is ignored.
- ctrl_* ranges stay stable from S_LAUNCH until the next pop.
- sched_busy = (state != S_IDLE) | !empty.
- Back-to-back jobs: minimum 3 cycles of scheduler overhead per job (IDLE, LAUNCH, REPORT).

Decomposition:
- calculator_pkg gets:
  - sched_state_t enum {S_IDLE, S_LAUNCH, S_RUN, S_REPORT}
  - job_status_t enum {ST_OK, ST_TIMEOUT, ST_BAD_RANGE}
  - calc_job_t packed struct {rd_start, rd_end, wr_start, wr_end, id}
- Reuse the existing ADDR_W from calculator_pkg.
- One sub-module: calc_job_fifo.
  - Synchronous FIFO of calc_job_t, DEPTH entries.
  - push/pop/full/empty, with pointer-plus-wrap-bit full detection.

Test Plan:
- Single job rd 0..511, wr 768..1023; ctrl_done after 600 RUN cycles -> ctrl_start 2 cycles after acceptance; done_valid with id 0, status OK, cycles 600; ctrl_* = 0/511/768/1023.
- Bad range rd 0..511, wr 768..1000 -> no ctrl_start; done_status BAD_RANGE, done_cycles 0, within 3 cycles of the pop.
- ctrl_done withheld -> ctrl_abort pulses when counter = 5000; done_status TIMEOUT, cycles 5000; the next queued job launches afterwards.
- Push 6 jobs back-to-back while the first runs -> job_ready drops after 5 accepts (1 active + 4 queued); tags 0..4 reported in order; tag wraps 15 -> 0 over 17 jobs.
- ctrl_done and timeout coincident (done at cycle 5000) -> status OK, no ctrl_abort.
- rst low during S_RUN -> all outputs 0 immediately, FIFO empty, no done_valid; job_ready = 1 after release.
